// File: rtl/sw_event_arbiter.sv
// sw_event_arbiter
// Turns per-bit switch change pulses into pending events and serialises them
// onto a single valid/ready event stream with round-robin arbitration.
// A short warm-up window after reset masks the edge detector's settling.
//
// Handshake: an event transfers on a rising clk edge where event_valid and
// event_ready are both high. Once event_valid is raised, event_idx and
// event_level hold steady until that transfer. event_valid never depends
// combinationally on event_ready; every output comes straight from a flop.
module sw_event_arbiter #(
    parameter int NUM_BITS      = 18,
    parameter int IDX_W         = 5,
    parameter int WARMUP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_BITS-1:0] SW_edge_det,
    input  logic [NUM_BITS-1:0] SW_level,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [IDX_W-1:0]    event_idx,
    output logic                event_level,
    output logic [NUM_BITS-1:0] pending,
    output logic                overflow,
    input  logic                clear_overflow
);

    localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    // With no warm-up window the block comes out of reset ready to capture.
    localparam state_e RESET_STATE = (WARMUP_CYCLES == 0) ? ST_IDLE : ST_WARMUP;

    // State register is kept as a named enum so checkers can bind to it.
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [NUM_BITS-1:0]   pending_q, pending_d;
    logic [NUM_BITS-1:0]   lvl_q, lvl_d;
    logic                  valid_q, valid_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  level_q, level_d;
    logic                  overflow_q, overflow_d;

    // Round-robin search results.
    logic                  found;
    logic [IDX_W-1:0]      grant_idx;

    // Helper signals for the next-state logic.
    logic                  capture_en;
    logic                  out_free;
    logic                  do_grant;
    logic [NUM_BITS-1:0]   edge_m;
    logic [NUM_BITS-1:0]   grant_mask;
    logic                  ovf_set;

    // Find the first registered pending bit at or after the pointer, wrapping.
    always_comb begin
        int j;
        found     = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int i = 0; i < NUM_BITS; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_BITS) begin
                j = j - NUM_BITS;
            end
            if (!found && pending_q[j]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    // Next-state logic: warm-up count, arbitration, capture and overflow.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        level_d    = level_q;
        do_grant   = 1'b0;
        grant_mask = '0;

        // Edges only count once the detector has settled.
        capture_en = (state_q != ST_WARMUP);
        edge_m     = capture_en ? SW_edge_det : '0;

        // The output register is free when idle or when its event is taken.
        out_free = (state_q == ST_IDLE) || ((state_q == ST_PRESENT) && valid_q && event_ready);

        case (state_q)
            ST_WARMUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_PRESENT: begin
                if (out_free) begin
                    if (found) begin
                        do_grant   = 1'b1;
                        grant_mask = NUM_BITS'(1) << grant_idx;
                        valid_d    = 1'b1;
                        idx_d      = grant_idx;
                        level_d    = lvl_q[grant_idx];
                        ptr_d      = (grant_idx == IDX_W'(NUM_BITS - 1)) ? '0 : grant_idx + 1'b1;
                        state_d    = ST_PRESENT;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A bit granted this cycle may be re-armed by a fresh edge without
        // counting as overflow; any other edge on a pending bit collapses
        // into the existing event and keeps only the newest level.
        ovf_set   = |(edge_m & pending_q & ~grant_mask);
        pending_d = (pending_q & ~grant_mask) | edge_m;
        lvl_d     = (lvl_q & ~edge_m) | (SW_level & edge_m);

        // A set in the same cycle as a clear wins, so no overflow is lost.
        overflow_d = clear_overflow ? 1'b0 : overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            pending_q  <= '0;
            lvl_q      <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            level_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
            lvl_q      <= lvl_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign event_valid = valid_q;
    assign event_idx   = idx_q;
    assign event_level = level_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sw_event_arbiter.sv
// Directed bench for sw_event_arbiter: warm-up masking, single events,
// round-robin order, backpressure, overflow and mid-operation reset.
module tb_sw_event_arbiter;

    localparam int NUM_BITS = 18;
    localparam int IDX_W    = 5;

    logic                clk;
    logic                reset_n;
    logic [NUM_BITS-1:0] sw_edge_det;
    logic [NUM_BITS-1:0] sw_level;
    logic                event_valid;
    logic                event_ready;
    logic [IDX_W-1:0]    event_idx;
    logic                event_level;
    logic [NUM_BITS-1:0] pending;
    logic                overflow;
    logic                clear_overflow;

    int n_assert;
    int n_fail;

    sw_event_arbiter #(
        .NUM_BITS     (NUM_BITS),
        .IDX_W        (IDX_W),
        .WARMUP_CYCLES(2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .SW_edge_det   (sw_edge_det),
        .SW_level      (sw_level),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_idx     (event_idx),
        .event_level   (event_level),
        .pending       (pending),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_event(input string tag, input logic v, input logic [IDX_W-1:0] idx, input logic lvl);
        chk({tag, ".valid"}, 32'(event_valid), 32'(v));
        if (v) begin
            chk({tag, ".idx"}, 32'(event_idx), 32'(idx));
            chk({tag, ".level"}, 32'(event_level), 32'(lvl));
        end
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        sw_edge_det    = '0;
        sw_level       = '0;
        event_ready    = 1'b0;
        clear_overflow = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.valid", 32'(event_valid), 32'd0);
        chk("rst.idx", 32'(event_idx), 32'd0);
        chk("rst.level", 32'(event_level), 32'd0);
        chk("rst.pending", 32'(pending), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);

        // Warm-up mask: cycle 0 idle, pulse in cycle 1 is ignored
        reset_n = 1'b1;
        tick();
        sw_edge_det = 18'h00001;
        sw_level    = 18'h00001;
        tick();
        sw_edge_det = '0;
        chk("warm.pending_c1", 32'(pending), 32'd0);
        chk("warm.ovf_c1", 32'(overflow), 32'd0);
        tick();
        chk("warm.pending_c2", 32'(pending), 32'd0);
        chk("warm.valid_c2", 32'(event_valid), 32'd0);
        // Same pulse in cycle 3 is captured; event appears in cycle 5
        sw_edge_det = 18'h00001;
        tick();
        sw_edge_det = '0;
        event_ready = 1'b1;
        chk("warm.pending_c4", 32'(pending), 32'h00001);
        chk("warm.valid_c4", 32'(event_valid), 32'd0);
        tick();
        chk_event("warm.ev_c5", 1'b1, 5'd0, 1'b1);
        chk("warm.pending_c5", 32'(pending), 32'd0);
        tick();
        chk("warm.valid_done", 32'(event_valid), 32'd0);

        // Single event on bit 4, rising
        sw_level    = 18'h00010;
        sw_edge_det = 18'h00010;
        tick();
        sw_edge_det = '0;
        chk("single.pending", 32'(pending), 32'h00010);
        tick();
        chk_event("single.ev", 1'b1, 5'd4, 1'b1);
        chk("single.pending_clr", 32'(pending), 32'd0);
        tick();
        chk("single.valid_done", 32'(event_valid), 32'd0);

        // Round-robin: bits 0 and 3 with pointer at 5 wrap to 0 first
        sw_level    = 18'h00009;
        sw_edge_det = 18'h00009;
        tick();
        sw_edge_det = '0;
        chk("rr1.pending", 32'(pending), 32'h00009);
        tick();
        chk_event("rr1.ev0", 1'b1, 5'd0, 1'b1);
        chk("rr1.pending_after0", 32'(pending), 32'h00008);
        tick();
        chk_event("rr1.ev3", 1'b1, 5'd3, 1'b1);
        tick();
        chk("rr1.valid_done", 32'(event_valid), 32'd0);

        // Round-robin: bits 0 and 5 with pointer at 4 give 5 then 0
        sw_level    = 18'h00020;
        sw_edge_det = 18'h00021;
        tick();
        sw_edge_det = '0;
        chk("rr2.pending", 32'(pending), 32'h00021);
        tick();
        chk_event("rr2.ev5", 1'b1, 5'd5, 1'b1);
        tick();
        chk_event("rr2.ev0", 1'b1, 5'd0, 1'b0);
        tick();
        chk("rr2.valid_done", 32'(event_valid), 32'd0);

        // Backpressure: idx 7 held for 5 cycles, idx 9 follows acceptance
        event_ready = 1'b0;
        sw_level    = 18'h00080;
        sw_edge_det = 18'h00280;
        tick();
        sw_edge_det = '0;
        chk("bp.pending", 32'(pending), 32'h00280);
        tick();
        chk_event("bp.ev7", 1'b1, 5'd7, 1'b1);
        chk("bp.pending_rest", 32'(pending), 32'h00200);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_event($sformatf("bp.hold%0d", i), 1'b1, 5'd7, 1'b1);
        end
        event_ready = 1'b1;
        tick();
        chk_event("bp.ev9", 1'b1, 5'd9, 1'b0);
        chk("bp.pending_clr", 32'(pending), 32'd0);
        tick();
        chk("bp.valid_done", 32'(event_valid), 32'd0);

        // Overflow: bit 11 held while bit 2 changes twice
        event_ready = 1'b0;
        sw_level    = 18'h00800;
        sw_edge_det = 18'h00800;
        tick();
        sw_edge_det = '0;
        tick();
        chk_event("ovf.ev11", 1'b1, 5'd11, 1'b1);
        sw_level    = 18'h00804;
        sw_edge_det = 18'h00004;
        tick();
        chk("ovf.pending1", 32'(pending), 32'h00004);
        chk("ovf.flag_before", 32'(overflow), 32'd0);
        sw_level    = 18'h00800;
        sw_edge_det = 18'h00004;
        tick();
        sw_edge_det = '0;
        chk("ovf.pending2", 32'(pending), 32'h00004);
        chk("ovf.flag_set", 32'(overflow), 32'd1);
        chk_event("ovf.still11", 1'b1, 5'd11, 1'b1);
        event_ready = 1'b1;
        tick();
        chk_event("ovf.ev2", 1'b1, 5'd2, 1'b0);
        chk("ovf.pending_clr", 32'(pending), 32'd0);
        tick();
        chk("ovf.one_event", 32'(event_valid), 32'd0);
        chk("ovf.sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf.cleared", 32'(overflow), 32'd0);

        // Reset mid-operation with everything pending and an event presented
        event_ready = 1'b0;
        sw_level    = 18'h3FFFF;
        sw_edge_det = 18'h3FFFF;
        tick();
        chk("mid.pending_all", 32'(pending), 32'h3FFFF);
        tick();
        chk_event("mid.ev3", 1'b1, 5'd3, 1'b1);
        chk("mid.pending_all2", 32'(pending), 32'h3FFFF);
        chk("mid.ovf", 32'(overflow), 32'd1);
        sw_edge_det = '0;
        reset_n     = 1'b0;
        #1;
        chk("mid.valid0", 32'(event_valid), 32'd0);
        chk("mid.idx0", 32'(event_idx), 32'd0);
        chk("mid.level0", 32'(event_level), 32'd0);
        chk("mid.pending0", 32'(pending), 32'd0);
        chk("mid.ovf0", 32'(overflow), 32'd0);
        tick();
        // Release; edges during the warm-up window are dropped
        reset_n     = 1'b1;
        event_ready = 1'b1;
        sw_edge_det = 18'h3FFFF;
        tick();
        chk("post.pending_c0", 32'(pending), 32'd0);
        tick();
        sw_edge_det = '0;
        chk("post.pending_c1", 32'(pending), 32'd0);
        chk("post.valid_c1", 32'(event_valid), 32'd0);
        tick();
        chk("post.valid_c2", 32'(event_valid), 32'd0);
        chk("post.ovf", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
